// File: rtl/audio_echo_engine_if.sv
// Sample-path bundle between the capture side, the echo engine and the output
// registers. The master drives a stereo pair with its echo settings; the slave returns the processed pair.
interface audio_echo_engine_if #(
  parameter int DEPTH_LOG2 = 12,
  parameter int DW         = 16
);
  logic                  sample_strobe;
  logic signed [DW-1:0]  in_l;
  logic signed [DW-1:0]  in_r;
  logic [DEPTH_LOG2-1:0] delay_len;
  logic [2:0]            fb_shift;
  logic                  wet_en;
  logic signed [DW-1:0]  out_l;
  logic signed [DW-1:0]  out_r;
  logic                  out_valid;
  logic                  busy;
  logic                  overrun;

  modport master (
    output sample_strobe, in_l, in_r, delay_len, fb_shift, wet_en,
    input  out_l, out_r, out_valid, busy, overrun
  );

  modport slave (
    input  sample_strobe, in_l, in_r, delay_len, fb_shift, wet_en,
    output out_l, out_r, out_valid, busy, overrun
  );
endinterface

// File: rtl/audio_echo_engine.sv
// Stereo feedback echo: mixes each pair with an attenuated, delayed copy of
// earlier output from a circular buffer and writes the mix back.
module audio_echo_engine #(
  parameter int DEPTH_LOG2 = 12,
  parameter int DW         = 16
) (
  input logic               CLOCK_50,
  input logic               AUD_DACLRCK,
  audio_echo_engine_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [2:0] {IDLE, RD, WAIT, MIX, WR} state_t;

  state_t                state_q, state_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0]   fill_q, fill_d;
  logic signed [DW-1:0]  out_l_q, out_l_d;
  logic signed [DW-1:0]  out_r_q, out_r_d;
  logic                  overrun_q, overrun_d;

  logic signed [DW-1:0]  x_l_q, x_r_q;
  logic signed [DW-1:0]  d_l_q, d_r_q;
  logic [DEPTH_LOG2-1:0] rd_addr_q;
  logic [DEPTH_LOG2:0]   eff_delay_q;
  logic [2:0]            fb_shift_q;
  logic                  wet_en_q;

  logic [2*DW-1:0]       mem [DEPTH];
  logic [2*DW-1:0]       ram_rdata_q;
  logic [DEPTH_LOG2-1:0] ram_addr;
  logic                  ram_we;

  logic                  accept;
  logic                  no_echo;
  logic signed [DW-1:0]  y_l, y_r;

  function automatic logic signed [DW-1:0] sat(input logic signed [DW:0] v);
    logic signed [DW:0] hi, lo;
    hi = {2'b00, {(DW-1){1'b1}}};
    lo = {2'b11, {(DW-1){1'b0}}};
    if (v > hi) return hi[DW-1:0];
    if (v < lo) return lo[DW-1:0];
    return v[DW-1:0];
  endfunction

  function automatic logic signed [DW-1:0] mix(input logic signed [DW-1:0] x,
                                               input logic signed [DW-1:0] d,
                                               input logic [2:0]           sh,
                                               input logic                 bypass);
    logic signed [DW-1:0] ds;
    logic signed [DW:0]   xe, de;
    if (bypass) return x;
    ds = d >>> sh;
    xe = x;
    de = ds;
    return sat(xe + de);
  endfunction

  assign accept = (state_q == IDLE) && bus.sample_strobe;

  // Unwritten locations hold stale data from before reset, so the echo term
  // is dropped until at least eff_delay pairs have been written.
  assign no_echo = !wet_en_q || (fb_shift_q == 3'd0) || (eff_delay_q > fill_q);
  assign y_l     = mix(x_l_q, d_l_q, fb_shift_q, no_echo);
  assign y_r     = mix(x_r_q, d_r_q, fb_shift_q, no_echo);

  // The single RAM port is shared: read address during RD, write pointer during WR.
  assign ram_we   = (state_q == WR);
  assign ram_addr = ram_we ? wr_ptr_q : rd_addr_q;

  always_ff @(posedge CLOCK_50) begin
    if (ram_we) mem[ram_addr] <= {out_l_q, out_r_q};
    ram_rdata_q <= mem[ram_addr];
  end

  always_ff @(posedge CLOCK_50) begin
    if (accept) begin
      x_l_q       <= bus.in_l;
      x_r_q       <= bus.in_r;
      fb_shift_q  <= bus.fb_shift;
      wet_en_q    <= bus.wet_en;
      rd_addr_q   <= wr_ptr_q - bus.delay_len;
      eff_delay_q <= (bus.delay_len == '0) ? FULL : {1'b0, bus.delay_len};
    end
    if (state_q == WAIT) begin
      d_l_q <= ram_rdata_q[2*DW-1:DW];
      d_r_q <= ram_rdata_q[DW-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    fill_d    = fill_q;
    out_l_d   = out_l_q;
    out_r_d   = out_r_q;
    overrun_d = overrun_q | (bus.sample_strobe && (state_q != IDLE));
    case (state_q)
      IDLE: if (bus.sample_strobe) state_d = RD;
      RD:   state_d = WAIT;
      WAIT: state_d = MIX;
      MIX: begin
        // Outputs load on entry to WR so they are valid alongside out_valid.
        state_d = WR;
        out_l_d = y_l;
        out_r_d = y_r;
      end
      WR: begin
        state_d  = IDLE;
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (fill_q != FULL) fill_d = fill_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge AUD_DACLRCK) begin
    if (!AUD_DACLRCK) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      fill_q    <= '0;
      out_l_q   <= '0;
      out_r_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      fill_q    <= fill_d;
      out_l_q   <= out_l_d;
      out_r_q   <= out_r_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.out_l     = out_l_q;
  assign bus.out_r     = out_r_q;
  assign bus.out_valid = (state_q == WR);
  assign bus.busy      = (state_q != IDLE);
  assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_audio_echo_engine.sv
// Directed bench for audio_echo_engine with a 16-pair buffer; expected pairs
// are queued at each strobe and checked by a monitor when out_valid pulses.
module tb_audio_echo_engine;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;
  int   vcnt  = 0;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    int          cyc;
    string       tag;
  } exp_t;
  exp_t q[$];

  audio_echo_engine_if #(.DEPTH_LOG2(4), .DW(16)) bus ();

  audio_echo_engine #(.DEPTH_LOG2(4), .DW(16)) dut (
    .CLOCK_50   (clk),
    .AUD_DACLRCK(rst_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [15:0] al, ar;
    if (bus.out_valid === 1'b1) begin
      vcnt <= vcnt + 1;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got out_l=0x%0h out_r=0x%0h with no pair expected (cycle %0d)",
                 bus.out_l, bus.out_r, cyc);
      end else begin
        e  = q.pop_front();
        al = bus.out_l;
        ar = bus.out_r;
        chk({e.tag, "_l"}, al, e.l);
        chk({e.tag, "_r"}, ar, e.r);
        chk({e.tag, "_latency"}, cyc, e.cyc);
      end
    end
  end

  task automatic pulse(input logic [15:0] l, input logic [15:0] r, input logic [3:0] dl,
                       input logic [2:0] fs, input logic we, input logic expect_out,
                       input logic [15:0] el, input logic [15:0] er, input string tag);
    exp_t e;
    @(negedge clk);
    bus.sample_strobe = 1'b1;
    bus.in_l          = l;
    bus.in_r          = r;
    bus.delay_len     = dl;
    bus.fb_shift      = fs;
    bus.wet_en        = we;
    if (expect_out) begin
      e.l   = el;
      e.r   = er;
      e.cyc = cyc + 4;
      e.tag = tag;
      q.push_back(e);
    end
    @(negedge clk);
    bus.sample_strobe = 1'b0;
  endtask

  task automatic xfer(input logic [15:0] l, input logic [15:0] r, input logic [3:0] dl,
                      input logic [2:0] fs, input logic we,
                      input logic [15:0] el, input logic [15:0] er, input string tag);
    pulse(l, r, dl, fs, we, 1'b1, el, er, tag);
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_state", {bus.out_l, bus.out_r}, 32'h0);
    chk("reset_flags", {29'h0, bus.out_valid, bus.busy, bus.overrun}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int v0;
    int nb;
    int el, er;
    bus.sample_strobe = 1'b0;
    bus.in_l          = '0;
    bus.in_r          = '0;
    bus.delay_len     = '0;
    bus.fb_shift      = '0;
    bus.wet_en        = 1'b0;

    do_reset();

    // Pass-through, latency and busy width
    pulse(16'h1234, 16'hFEDC, 4'd1, 3'd1, 1'b0, 1'b1, 16'h1234, 16'hFEDC, "pass");
    nb = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.busy === 1'b1) nb++;
      @(negedge clk);
    end
    chk("busy_cycles", nb, 4);

    // Echo with fill gating on the first three pairs
    do_reset();
    xfer(16'h4000, 16'h0000, 4'd3, 3'd1, 1'b1, 16'h4000, 16'h0000, "echo0");
    xfer(16'h0000, 16'h0000, 4'd3, 3'd1, 1'b1, 16'h0000, 16'h0000, "echo1");
    xfer(16'h0000, 16'h0000, 4'd3, 3'd1, 1'b1, 16'h0000, 16'h0000, "echo2");
    xfer(16'h0000, 16'h0000, 4'd3, 3'd1, 1'b1, 16'h2000, 16'h0000, "echo3");

    // Saturation at both rails, then echo disabled by fb_shift=0 and wet_en=0
    do_reset();
    xfer(16'h7000, 16'h9000, 4'd1, 3'd1, 1'b1, 16'h7000, 16'h9000, "sat0");
    xfer(16'h7000, 16'h9000, 4'd1, 3'd1, 1'b1, 16'h7FFF, 16'h8000, "sat1");
    xfer(16'h7000, 16'h9000, 4'd1, 3'd1, 1'b1, 16'h7FFF, 16'h8000, "sat2");
    xfer(16'h0100, 16'hFF00, 4'd1, 3'd0, 1'b1, 16'h0100, 16'hFF00, "fb0");
    xfer(16'h0200, 16'hFE00, 4'd1, 3'd1, 1'b0, 16'h0200, 16'hFE00, "dry");

    // Full-depth delay with wrap-around; right channel negative to exercise the arithmetic shift
    do_reset();
    for (int n = 0; n < 20; n++) begin
      el = n * 256;
      er = -(n * 16);
      if (n >= 16) begin
        el = el + (((n - 16) * 256) >>> 2);
        er = er + ((-((n - 16) * 16)) >>> 2);
      end
      xfer(16'(n * 256), 16'(-(n * 16)), 4'd0, 3'd2, 1'b1, 16'(el), 16'(er), "wrap");
    end

    // Strobe two cycles into a transaction is dropped and flagged
    do_reset();
    v0 = vcnt;
    pulse(16'h0500, 16'h0000, 4'd1, 3'd1, 1'b1, 1'b1, 16'h0500, 16'h0000, "ovr_a");
    pulse(16'h7777, 16'h7777, 4'd1, 3'd1, 1'b1, 1'b0, 16'h0, 16'h0, "drop");
    repeat (5) @(negedge clk);
    chk("ovr_valid_count", vcnt - v0, 1);
    chk("ovr_flag", {31'h0, bus.overrun}, 1);
    xfer(16'h0100, 16'h0000, 4'd1, 3'd1, 1'b1, 16'h0380, 16'h0000, "ovr_next");
    chk("ovr_sticky", {31'h0, bus.overrun}, 1);

    // Strobe in the WR cycle is also an overrun
    do_reset();
    v0 = vcnt;
    pulse(16'h0400, 16'h0000, 4'd1, 3'd1, 1'b1, 1'b1, 16'h0400, 16'h0000, "wr_a");
    repeat (2) @(negedge clk);
    pulse(16'h7777, 16'h7777, 4'd1, 3'd1, 1'b1, 1'b0, 16'h0, 16'h0, "drop");
    repeat (5) @(negedge clk);
    chk("wr_ovr_count", vcnt - v0, 1);
    chk("wr_ovr_flag", {31'h0, bus.overrun}, 1);

    // Strobe five cycles later is accepted back to back
    do_reset();
    v0 = vcnt;
    pulse(16'h0400, 16'h0000, 4'd1, 3'd1, 1'b1, 1'b1, 16'h0400, 16'h0000, "b2b_a");
    repeat (3) @(negedge clk);
    pulse(16'h0100, 16'h0000, 4'd1, 3'd1, 1'b1, 1'b1, 16'h0300, 16'h0000, "b2b_b");
    repeat (5) @(negedge clk);
    chk("b2b_count", vcnt - v0, 2);
    chk("b2b_no_ovr", {31'h0, bus.overrun}, 0);

    // Reset in the middle of a transaction aborts it
    do_reset();
    xfer(16'h0600, 16'h0700, 4'd1, 3'd1, 1'b0, 16'h0600, 16'h0700, "pre_abort");
    v0 = vcnt;
    pulse(16'h1111, 16'h2222, 4'd1, 3'd1, 1'b1, 1'b0, 16'h0, 16'h0, "abort");
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_outs", {bus.out_l, bus.out_r}, 32'h0);
    chk("abort_flags", {29'h0, bus.out_valid, bus.busy, bus.overrun}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_no_valid", vcnt - v0, 0);
    xfer(16'h0321, 16'h0FED, 4'd1, 3'd1, 1'b1, 16'h0321, 16'h0FED, "post_abort");

    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    chk("drain", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
